// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with iterative MULT/DIV engines feeding HI/LO.
// Results are registered and held until the consumer takes them.
`default_nettype none

module alu_seq_core #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                error
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'('h00);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'('h01);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'('h02);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'('h03);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'('h04);
  localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'('h05);
  localparam logic [OP_WIDTH-1:0] OP_NAND = OP_WIDTH'('h06);
  localparam logic [OP_WIDTH-1:0] OP_XNOR = OP_WIDTH'('h07);
  localparam logic [OP_WIDTH-1:0] OP_EQU  = OP_WIDTH'('h08);
  localparam logic [OP_WIDTH-1:0] OP_GT   = OP_WIDTH'('h09);
  localparam logic [OP_WIDTH-1:0] OP_LT   = OP_WIDTH'('h0A);
  localparam logic [OP_WIDTH-1:0] OP_ROTR = OP_WIDTH'('h0B);
  localparam logic [OP_WIDTH-1:0] OP_ROTL = OP_WIDTH'('h0C);
  localparam logic [OP_WIDTH-1:0] OP_MULT = OP_WIDTH'('h0D);
  localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'('h0E);
  localparam logic [OP_WIDTH-1:0] OP_MFLO = OP_WIDTH'('h0F);
  localparam logic [OP_WIDTH-1:0] OP_MFHI = OP_WIDTH'('h10);

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     quo_q, rem_q, dvs_q;
  logic [CW-1:0]        cnt_q;

  // Shift-add multiplier step
  logic [2*WIDTH-1:0] mul_acc_d;
  assign mul_acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Restoring divider step: remainder stays below the divisor, so bit WIDTH
  // of the trial difference is a clean "went negative" indicator.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_d, quo_d;
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_d     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_d     = {quo_q[WIDTH-2:0], div_ge};

  logic [WIDTH:0]   sum, dif;
  logic [31:0]      rot_amt;
  logic [WIDTH-1:0] rotr, rotl;
  assign sum     = {1'b0, a} + {1'b0, b};
  assign dif     = {1'b0, a} - {1'b0, b};
  assign rot_amt = 32'(b) % 32'(WIDTH);
  assign rotr    = (a >> rot_amt) | (a << (32'(WIDTH) - rot_amt));
  assign rotl    = (a << rot_amt) | (a >> (32'(WIDTH) - rot_amt));

  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d, err_d;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = dif[WIDTH-1:0];
        carry_d = dif[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_NOR:  res_d = ~(a | b);
      OP_NAND: res_d = ~(a & b);
      OP_XNOR: res_d = ~(a ^ b);
      OP_EQU:  res_d = WIDTH'(a == b);
      OP_GT:   res_d = WIDTH'(a > b);
      OP_LT:   res_d = WIDTH'(a < b);
      OP_ROTR: res_d = rotr;
      OP_ROTL: res_d = rotl;
      OP_MULT: res_d = '0;
      // Only reached with b == 0; nonzero divisors go to the engine
      OP_DIV:  err_d = 1'b1;
      OP_MFLO: res_d = lo_q;
      OP_MFHI: res_d = hi_q;
      default: err_d = 1'b1;
    endcase
  end

  assign in_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      error     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MULT) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              cnt_q    <= '0;
              state_q  <= MUL;
            end else if (op == OP_DIV && b != '0) begin
              quo_q   <= a;
              rem_q   <= '0;
              dvs_q   <= b;
              cnt_q   <= '0;
              state_q <= DIV;
            end else begin
              result    <= res_d;
              zero      <= (res_d == '0);
              carry     <= carry_d;
              overflow  <= ovf_d;
              error     <= err_d;
              out_valid <= 1'b1;
              state_q   <= HOLD;
            end
          end
        end
        MUL: begin
          acc_q    <= mul_acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_q      <= mul_acc_d[2*WIDTH-1:WIDTH];
            lo_q      <= mul_acc_d[WIDTH-1:0];
            result    <= mul_acc_d[WIDTH-1:0];
            zero      <= (mul_acc_d[WIDTH-1:0] == '0);
            carry     <= 1'b0;
            overflow  <= (mul_acc_d[2*WIDTH-1:WIDTH] != '0);
            error     <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_q      <= rem_d;
            lo_q      <= quo_d;
            result    <= quo_d;
            zero      <= (quo_d == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            error     <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=8.
`default_nettype none

module tb_alu_seq_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] op;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero, carry, overflow, error;

  int checks   = 0;
  int failures = 0;

  alu_seq_core #(.WIDTH(8), .OP_WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result, check it, optionally stall, then consume.
  task automatic run(input string name, input logic [4:0] op_v, input logic [7:0] a_v,
                     input logic [7:0] b_v, input int lat, input logic [7:0] r,
                     input logic z, input logic c, input logic o, input logic e,
                     input int hold);
    int   cyc;
    logic busy_ok;
    logic [7:0] r_seen;
    in_valid = 1'b1;
    op = op_v;
    a  = a_v;
    b  = b_v;
    step();
    in_valid = 1'b0;
    a = ~a_v;
    b = ~b_v;
    cyc = 1;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) busy_ok = 1'b0;
      step();
      cyc++;
    end
    chk({name, " latency"}, cyc, lat);
    chk({name, " out_valid"}, out_valid, 1'b1);
    chk({name, " result"}, result, r);
    chk({name, " zero"}, zero, z);
    chk({name, " carry"}, carry, c);
    chk({name, " overflow"}, overflow, o);
    chk({name, " error"}, error, e);
    chk({name, " in_ready_busy"}, {busy_ok, in_ready}, 2'b10);
    r_seen = result;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({name, " hold"}, {out_valid, in_ready, result, zero, carry, overflow, error},
          {1'b1, 1'b0, r_seen, z, c, o, e});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, " release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    step();
    step();
    chk("reset_outputs", {out_valid, result, zero, carry, overflow, error},
        {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);

    //   name     op     a      b      lat res    z     c     o     e     hold
    run("ADD",  5'h00, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run("SUB",  5'h01, 8'h00, 8'h01, 1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run("MULT", 5'h0D, 8'hFF, 8'hFF, 9, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run("MFHI1",5'h10, 8'h00, 8'h00, 1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("MFLO1",5'h0F, 8'h00, 8'h00, 1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("DIV",  5'h0E, 8'h64, 8'h07, 9, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("MFHI2",5'h10, 8'h00, 8'h00, 1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("DIV0", 5'h0E, 8'h10, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run("MFHI3",5'h10, 8'h00, 8'h00, 1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("BADOP",5'h1F, 8'h12, 8'h34, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run("MFLO2",5'h0F, 8'h00, 8'h00, 1, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("EQU",  5'h08, 8'h5A, 8'h5A, 1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("GT",   5'h09, 8'h5A, 8'h3C, 1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("LT",   5'h0A, 8'h5A, 8'h3C, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run("XOR",  5'h04, 8'h5A, 8'h5A, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run("NAND", 5'h06, 8'hF0, 8'h3C, 1, 8'hCF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("ROTR", 5'h0B, 8'h81, 8'h01, 1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("ADDC", 5'h00, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run("MULT2",5'h0D, 8'h0C, 8'h0B, 9, 8'h84, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("ROTL", 5'h0C, 8'h81, 8'h09, 1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 5);

    // Reset in the 4th cycle of a MULT discards it and clears HI/LO
    in_valid = 1'b1;
    op = 5'h0D;
    a  = 8'h12;
    b  = 8'h34;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_state", {out_valid, in_ready, result, zero, error},
        {1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) step();
    chk("midreset_no_result", out_valid, 1'b0);
    run("MFLO3",5'h0F, 8'h00, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run("MFHI4",5'h10, 8'h00, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
